// File: rtl/cmd_pkt_parser.sv
// cmd_pkt_parser: host command frame parser on the FT232 receive path.
// Consumes RX FIFO bytes, checks framing, length and checksum, buffers the
// payload and holds each good frame until the consumer acknowledges it.
// Bad frames raise one err_pulse bit and bump a saturating error counter.
module cmd_pkt_parser #(
  parameter int         LEN_BYTES   = 2,
  parameter int         MAX_PAYLOAD = 32,
  parameter int         TIMEOUT_CYC = 50000,
  parameter logic [7:0] HDR_BYTE    = 8'h3A,
  parameter logic [7:0] TAIL_BYTE   = 8'h0A,
  localparam int        LW          = 8 * LEN_BYTES,
  localparam int        AW          = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          pkt_valid,
  input  logic          pkt_ack,
  output logic [15:0]   pkt_cmd,
  output logic [LW-1:0] pkt_len,
  input  logic [AW-1:0] pl_raddr,
  output logic [7:0]    pl_rdata,
  output logic [3:0]    err_pulse,
  output logic [15:0]   err_cnt
);

  localparam int            TW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [1:0]    LB_LAST = 2'(LEN_BYTES - 1);
  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_CMD_L, S_CMD_H, S_PAYLOAD, S_CHK, S_TAIL, S_HOLD
  } state_t;

  state_t        state;
  logic [1:0]    lb_idx;
  logic [LW-1:0] len_q;
  logic [LW-1:0] idx;
  logic [15:0]   cmd_q;
  logic [7:0]    sum_q;
  logic [TW-1:0] tcnt;
  logic [7:0]    mem [MAX_PAYLOAD];

  logic          accept;
  logic          in_frame;
  logic [LW-1:0] len_new;
  logic [7:0]    sum_new;
  logic [15:0]   cnt_inc;

  assign in_ready = (state != S_HOLD);
  assign pl_rdata = mem[pl_raddr];

  // Byte handshake, partial LEN assembly and 8-bit running checksum
  always_comb begin
    accept   = in_valid && in_ready;
    in_frame = (state != S_IDLE) && (state != S_HOLD);
    len_new  = len_q | (LW'(in_data) << (8 * lb_idx));
    sum_new  = sum_q + in_data;
    cnt_inc  = (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
  end

  // Frame FSM with inter-byte timeout, latched outputs and error reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lb_idx    <= '0;
      len_q     <= '0;
      idx       <= '0;
      cmd_q     <= '0;
      sum_q     <= '0;
      tcnt      <= '0;
      pkt_valid <= 1'b0;
      pkt_cmd   <= '0;
      pkt_len   <= '0;
      err_pulse <= '0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= '0;
      if (in_frame && !accept) begin
        if (TIMEOUT_CYC != 0 && tcnt == TO_LAST) begin
          err_pulse <= 4'b1000;
          err_cnt   <= cnt_inc;
          state     <= S_IDLE;
          tcnt      <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
      end

      if (accept) begin
        case (state)
          S_IDLE: begin
            if (in_data == HDR_BYTE) begin
              state  <= S_LEN;
              lb_idx <= '0;
              len_q  <= '0;
              idx    <= '0;
              sum_q  <= '0;
            end
          end
          S_LEN: begin
            sum_q  <= sum_new;
            len_q  <= len_new;
            lb_idx <= lb_idx + 2'd1;
            if (lb_idx == LB_LAST) begin
              if (len_new > MAX_LEN) begin
                err_pulse <= 4'b0001;
                err_cnt   <= cnt_inc;
                state     <= S_IDLE;
              end else begin
                state <= S_CMD_L;
              end
            end
          end
          S_CMD_L: begin
            sum_q      <= sum_new;
            cmd_q[7:0] <= in_data;
            state      <= S_CMD_H;
          end
          S_CMD_H: begin
            sum_q       <= sum_new;
            cmd_q[15:8] <= in_data;
            state       <= (len_q == '0) ? S_CHK : S_PAYLOAD;
          end
          S_PAYLOAD: begin
            sum_q <= sum_new;
            idx   <= idx + 1'b1;
            if (idx == len_q - 1'b1) state <= S_CHK;
          end
          S_CHK: begin
            if (sum_new != 8'h00) begin
              err_pulse <= 4'b0010;
              err_cnt   <= cnt_inc;
              state     <= S_IDLE;
            end else begin
              state <= S_TAIL;
            end
          end
          S_TAIL: begin
            if (in_data != TAIL_BYTE) begin
              err_pulse <= 4'b0100;
              err_cnt   <= cnt_inc;
              state     <= S_IDLE;
            end else begin
              pkt_valid <= 1'b1;
              pkt_cmd   <= cmd_q;
              pkt_len   <= len_q;
              state     <= S_HOLD;
            end
          end
          default: ;
        endcase
      end

      if (state == S_HOLD && pkt_ack) begin
        pkt_valid <= 1'b0;
        state     <= S_IDLE;
      end
    end
  end

  // Payload buffer write; intentionally not reset
  always_ff @(posedge clk) begin
    if (accept && state == S_PAYLOAD) mem[idx[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_cmd_pkt_parser.sv
// Testbench for cmd_pkt_parser: directed frames from the datasheet examples
// followed by randomized good/bad frames, scored against frame-level expectations.
module tb_cmd_pkt_parser;

  localparam int LEN_BYTES   = 2;
  localparam int MAX_PAYLOAD = 32;
  localparam int TIMEOUT_CYC = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        pkt_valid;
  logic        pkt_ack = 1'b0;
  logic [15:0] pkt_cmd;
  logic [15:0] pkt_len;
  logic [4:0]  pl_raddr = 5'd0;
  logic [7:0]  pl_rdata;
  logic [3:0]  err_pulse;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  cmd_pkt_parser #(
    .LEN_BYTES(LEN_BYTES), .MAX_PAYLOAD(MAX_PAYLOAD), .TIMEOUT_CYC(TIMEOUT_CYC),
    .HDR_BYTE(8'h3A), .TAIL_BYTE(8'h0A)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .pkt_valid(pkt_valid), .pkt_ack(pkt_ack),
    .pkt_cmd(pkt_cmd), .pkt_len(pkt_len), .pl_raddr(pl_raddr),
    .pl_rdata(pl_rdata), .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  int n_compared = 0;
  int n_mismatched = 0;

  int pulse_cnt [4] = '{0, 0, 0, 0};
  int exp_pulse [4] = '{0, 0, 0, 0};
  int multi_cnt = 0;
  int exp_err_cnt = 0;
  logic [15:0] last_cmd = 16'h0;
  logic [15:0] last_len = 16'h0;

  logic [7:0] frame_q [$];
  logic [7:0] payload [MAX_PAYLOAD];

  // Count error pulse cycles per bit and cycles with more than one bit set
  always @(negedge clk) begin
    if (rst_n) begin
      for (int b = 0; b < 4; b++) if (err_pulse[b]) pulse_cnt[b]++;
      if ($countones(err_pulse) > 1) multi_cnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame assembled from its fields; checksum makes the byte sum zero mod 256
  task automatic buildFrame(input int len, input logic [15:0] cmd, input int chk_delta,
                            input logic [7:0] tail);
    int sum;
    sum = 0;
    frame_q.delete();
    frame_q.push_back(8'h3A);
    frame_q.push_back(len[7:0]);
    frame_q.push_back(len[15:8]);
    frame_q.push_back(cmd[7:0]);
    frame_q.push_back(cmd[15:8]);
    sum = (len % 256) + ((len / 256) % 256) + cmd[7:0] + cmd[15:8];
    for (int i = 0; i < len; i++) begin
      frame_q.push_back(payload[i]);
      sum += payload[i];
    end
    frame_q.push_back(8'((256 - (sum % 256) + chk_delta) % 256));
    frame_q.push_back(tail);
  endtask

  task automatic sendByte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 500 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) checkOutput("byte_accept_bound", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input int max_gap);
    foreach (frame_q[i]) begin
      if (max_gap > 0) step($urandom_range(0, max_gap));
      sendByte(frame_q[i]);
    end
  endtask

  task automatic expectGood(input int len, input logic [15:0] cmd);
    checkOutput("pkt_valid_latency", {31'd0, pkt_valid}, 32'd1);
    checkOutput("pkt_cmd", {16'd0, pkt_cmd}, {16'd0, cmd});
    checkOutput("pkt_len", {16'd0, pkt_len}, len);
    checkOutput("in_ready_hold", {31'd0, in_ready}, 32'd0);
    checkOutput("err_cnt_good", {16'd0, err_cnt}, exp_err_cnt);
    for (int i = 0; i < len; i++) begin
      pl_raddr = 5'(i);
      #1;
      checkOutput($sformatf("payload[%0d]", i), {24'd0, pl_rdata}, {24'd0, payload[i]});
    end
    step($urandom_range(1, 3));
    checkOutput("pkt_valid_held", {31'd0, pkt_valid}, 32'd1);
    pkt_ack = 1'b1;
    step(1);
    pkt_ack = 1'b0;
    checkOutput("pkt_valid_after_ack", {31'd0, pkt_valid}, 32'd0);
    checkOutput("in_ready_after_ack", {31'd0, in_ready}, 32'd1);
    last_cmd = cmd;
    last_len = 16'(len);
  endtask

  task automatic expectError(input int bit_idx);
    step(2);
    exp_pulse[bit_idx]++;
    if (exp_err_cnt < 65535) exp_err_cnt++;
    for (int b = 0; b < 4; b++)
      checkOutput($sformatf("err_pulse_bit%0d", b), pulse_cnt[b], exp_pulse[b]);
    checkOutput("err_cnt", {16'd0, err_cnt}, exp_err_cnt);
    checkOutput("pkt_valid_err", {31'd0, pkt_valid}, 32'd0);
    checkOutput("pkt_cmd_kept", {16'd0, pkt_cmd}, {16'd0, last_cmd});
    checkOutput("pkt_len_kept", {16'd0, pkt_len}, {16'd0, last_len});
  endtask

  task automatic randomGood(input int len, input logic [15:0] cmd, input int max_gap);
    for (int i = 0; i < len; i++) payload[i] = 8'($urandom);
    buildFrame(len, cmd, 0, 8'h0A);
    applyStimulus(max_gap);
    expectGood(len, cmd);
  endtask

  function automatic logic [7:0] garbageByte();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'h3A) b = 8'h55;
    return b;
  endfunction

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int kind, len;
    logic [15:0] cmd;

    // Reset values
    rst_n = 1'b0;
    step(3);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
    checkOutput("rst_pkt_cmd", {16'd0, pkt_cmd}, 32'd0);
    checkOutput("rst_pkt_len", {16'd0, pkt_len}, 32'd0);
    checkOutput("rst_err_pulse", {28'd0, err_pulse}, 32'd0);
    checkOutput("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;
    step(1);

    // Datasheet good frame
    payload[0] = 8'h08; payload[1] = 8'h10;
    frame_q = '{8'h3A, 8'h02, 8'h00, 8'h02, 8'h00, 8'h08, 8'h10, 8'hE4, 8'h0A};
    applyStimulus(0);
    expectGood(2, 16'h0002);

    // Same frame with a bad checksum
    frame_q = '{8'h3A, 8'h02, 8'h00, 8'h02, 8'h00, 8'h08, 8'h10, 8'hE5, 8'h0A};
    applyStimulus(0);
    expectError(1);

    // Garbage before a good frame
    frame_q = '{8'h55, 8'hAA, 8'h3A, 8'h02, 8'h00, 8'h02, 8'h00, 8'h08, 8'h10, 8'hE4, 8'h0A};
    applyStimulus(0);
    expectGood(2, 16'h0002);

    // Zero-length payload
    frame_q = '{8'h3A, 8'h00, 8'h00, 8'h05, 8'h01, 8'hFA, 8'h0A};
    applyStimulus(0);
    expectGood(0, 16'h0105);

    // Length one above the buffer depth, then a good frame
    frame_q = '{8'h3A, 8'h21, 8'h00};
    applyStimulus(0);
    expectError(0);
    randomGood(5, 16'h1234, 0);

    // Maximum-length payload
    randomGood(MAX_PAYLOAD, 16'hBEEF, 1);

    // Back-to-back frames: second waits until the first is acknowledged
    for (int i = 0; i < 3; i++) payload[i] = 8'(8'h20 + i);
    buildFrame(3, 16'h00A1, 0, 8'h0A);
    applyStimulus(0);
    in_valid = 1'b1;
    in_data  = 8'h3A;
    for (int i = 0; i < 4; i++) begin
      step(1);
      checkOutput("b2b_in_ready_low", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    expectGood(3, 16'h00A1);
    randomGood(4, 16'h00A2, 0);

    // Long stall inside a frame after CMD_H
    frame_q = '{8'h3A, 8'h02, 8'h00, 8'h02, 8'h00};
    applyStimulus(0);
    step(TIMEOUT_CYC + 5);
    expectError(3);

    // A stall comfortably below the limit does not abort
    for (int i = 0; i < 6; i++) payload[i] = 8'($urandom);
    buildFrame(6, 16'h0C0C, 0, 8'h0A);
    foreach (frame_q[i]) begin
      if (i == 7) step(TIMEOUT_CYC - 5);
      sendByte(frame_q[i]);
    end
    expectGood(6, 16'h0C0C);

    // Reset in the middle of a payload
    for (int i = 0; i < 10; i++) payload[i] = 8'($urandom);
    buildFrame(10, 16'h7777, 0, 8'h0A);
    for (int i = 0; i < 8; i++) sendByte(frame_q[i]);
    rst_n = 1'b0;
    step(2);
    exp_err_cnt = 0;
    last_cmd = 16'h0;
    last_len = 16'h0;
    checkOutput("midrst_err_cnt", {16'd0, err_cnt}, 32'd0);
    checkOutput("midrst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
    checkOutput("midrst_pkt_cmd", {16'd0, pkt_cmd}, 32'd0);
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    step(1);
    randomGood(7, 16'h4242, 0);

    // Randomized mix of good and bad frames
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 4);
      cmd  = 16'($urandom);
      len  = $urandom_range(0, MAX_PAYLOAD);
      case (kind)
        0: randomGood(len, cmd, 3);
        1: begin
          for (int i = 0; i < len; i++) payload[i] = 8'($urandom);
          buildFrame(len, cmd, $urandom_range(1, 255), 8'h0A);
          applyStimulus(3);
          expectError(1);
        end
        2: begin
          logic [7:0] t;
          t = 8'($urandom);
          if (t == 8'h0A) t = 8'h0B;
          for (int i = 0; i < len; i++) payload[i] = 8'($urandom);
          buildFrame(len, cmd, 0, t);
          applyStimulus(3);
          expectError(2);
        end
        3: begin
          len = $urandom_range(MAX_PAYLOAD + 1, 65535);
          frame_q.delete();
          frame_q.push_back(8'h3A);
          frame_q.push_back(len[7:0]);
          frame_q.push_back(len[15:8]);
          applyStimulus(3);
          expectError(0);
        end
        default: begin
          for (int g = 0; g < int'($urandom_range(1, 6)); g++) sendByte(garbageByte());
          randomGood(len, cmd, 3);
        end
      endcase
    end

    checkOutput("single_bit_errors", multi_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
